// File: rtl/aes_round_ctrl_if.sv
// Bundle of the plaintext/ciphertext handshakes, key-schedule inputs and
// round-datapath connections of the AES-128 round sequencer.
interface aes_round_ctrl_if;
  logic [1407:0] w_all;
  logic [3:0]    key_ready_index;
  logic          in_valid;
  logic [127:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [127:0]  out_data;
  logic          out_ready;
  logic [127:0]  rd_state;
  logic [127:0]  rd_key;
  logic          rd_last;
  logic          rd_en;
  logic [127:0]  rd_result;
  logic [15:0]   stall_cnt;

  // Sequencer side
  modport slave (
    input  w_all, key_ready_index, in_valid, in_data, out_ready, rd_result,
    output in_ready, out_valid, out_data, rd_state, rd_key, rd_last, rd_en, stall_cnt
  );

  // Environment side: key schedule, producer, consumer and round datapath
  modport master (
    output w_all, key_ready_index, in_valid, in_data, out_ready, rd_result,
    input  in_ready, out_valid, out_data, rd_state, rd_key, rd_last, rd_en, stall_cnt
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: applies the round-0 key itself, then steps an
// external single-round datapath through rounds 1..10, stalling on key readiness.
module aes_round_ctrl (
  input  logic            clk,
  input  logic            rst,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDKEY = 3'd1,
    S_ROUND  = 3'd2,
    S_DONE   = 3'd3
  } fsm_e;

  fsm_e          fsm_r, fsm_s;
  logic [127:0]  state_r, state_s;
  logic [3:0]    round_r, round_s;
  logic [15:0]   stall_cnt_r, stall_cnt_s;
  logic          key_ok_s;

  function automatic logic [127:0] round_key(input logic [1407:0] w, input logic [3:0] r);
    logic [127:0] k;
    case (r)
      4'd0:    k = w[1407:1280];
      4'd1:    k = w[1279:1152];
      4'd2:    k = w[1151:1024];
      4'd3:    k = w[1023:896];
      4'd4:    k = w[895:768];
      4'd5:    k = w[767:640];
      4'd6:    k = w[639:512];
      4'd7:    k = w[511:384];
      4'd8:    k = w[383:256];
      4'd9:    k = w[255:128];
      4'd10:   k = w[127:0];
      default: k = 128'd0;
    endcase
    return k;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Key r is usable once r+1 keys (round 0 included) are ready; round_r is 0 in S_ADDKEY
  assign key_ok_s = ({1'b0, bus.key_ready_index} >= ({1'b0, round_r} + 5'd1));

  assign bus.in_ready  = (fsm_r == S_IDLE);
  assign bus.out_valid = (fsm_r == S_DONE);
  assign bus.rd_en     = (fsm_r == S_ROUND) && key_ok_s;
  assign bus.rd_last   = (fsm_r == S_ROUND) && (round_r == 4'd10);
  assign bus.rd_state  = state_r;
  assign bus.out_data  = state_r;
  assign bus.rd_key    = round_key(bus.w_all, round_r);
  assign bus.stall_cnt = stall_cnt_r;

  // Next-state logic for the sequencer and its datapath registers
  always_comb begin
    fsm_s       = fsm_r;
    state_s     = state_r;
    round_s     = round_r;
    stall_cnt_s = stall_cnt_r;
    case (fsm_r)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_s     = bus.in_data;
          round_s     = 4'd0;
          stall_cnt_s = 16'd0;
          fsm_s       = S_ADDKEY;
        end else begin
          fsm_s = S_IDLE;
        end
      end
      S_ADDKEY: begin
        if (key_ok_s) begin
          state_s = state_r ^ bus.w_all[1407:1280];
          round_s = 4'd1;
          fsm_s   = S_ROUND;
        end else begin
          stall_cnt_s = sat_inc(stall_cnt_r);
        end
      end
      S_ROUND: begin
        if (key_ok_s) begin
          state_s = bus.rd_result;
          if (round_r == 4'd10) begin
            fsm_s = S_DONE;
          end else begin
            round_s = round_r + 4'd1;
          end
        end else begin
          stall_cnt_s = sat_inc(stall_cnt_r);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          fsm_s = S_IDLE;
        end else begin
          fsm_s = S_DONE;
        end
      end
      default: begin
        fsm_s = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm_r       <= S_IDLE;
      state_r     <= 128'd0;
      round_r     <= 4'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      fsm_r       <= fsm_s;
      state_r     <= state_s;
      round_r     <= round_s;
      stall_cnt_r <= stall_cnt_s;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: software AES-128 round datapath and
// key schedule, plus a cycle-level reference of key-gated round progress.
module tb_aes_round_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_R1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus ();
  aes_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int num_tests = 0;
  int num_fail  = 0;

  // ---------------- AES software reference ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the FIPS-197 affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, b, e, s;
    r = 8'h01;
    b = a;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, b);
      b = gmul(b, b);
    end
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[4*c+r] = a[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = b[4*c+r];
      end else begin
        o[127-32*c -: 8] = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
        o[119-32*c -: 8] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
        o[111-32*c -: 8] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
        o[103-32*c -: 8] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
      end
    end
    return o ^ k;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] rk(input logic [1407:0] w, input int r);
    return w[1407-128*r -: 128];
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [1407:0] w);
    logic [127:0] s;
    s = pt ^ rk(w, 0);
    for (int r = 1; r <= 10; r++) s = aes_round(s, rk(w, r), r == 10);
    return s;
  endfunction

  // External round datapath
  assign bus.rd_result = aes_round(bus.rd_state, bus.rd_key, bus.rd_last);

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    num_tests++;
    if (got !== exp) begin
      num_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // ---------------- stimulus configuration and reference state ----------------
  int            kri_mode, or_mode, iv_mode;
  int            ramp_cnt, done_cnt, kri_walk, cyc, dut_acc_cyc;
  bit            lat_armed, rst_mid_pending;
  logic [127:0]  pt_q[$];
  logic [1407:0] cur_w, fips_w;

  // Reference: phase 0 idle, 1 working through keys m_k = 0..10, 2 holding result
  int            m_phase, m_k, m_stall;
  logic [127:0]  m_state, m_pt, m_ct;
  logic [1407:0] m_w;

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_stall = 0;
    m_state = 128'd0; m_pt = 128'd0; m_ct = 128'd0; m_w = '0;
    lat_armed = 1'b0;
  endtask

  task automatic run_cycle();
    int   kri_i;
    bit   do_rst, exp_en;
    // drive inputs
    do_rst = rst_mid_pending && (m_phase == 1) && (m_k == 5);
    if (do_rst) rst_mid_pending = 1'b0;
    rst = !do_rst;
    case (kri_mode)
      0: kri_i = 11;
      1: kri_i = (ramp_cnt / 8 > 11) ? 11 : ramp_cnt / 8;
      default: begin
        if ($urandom_range(15, 0) == 0) kri_walk = int'($urandom_range(kri_walk, 0));
        else if ($urandom_range(1, 0) == 1 && kri_walk < 15) kri_walk++;
        kri_i = kri_walk;
      end
    endcase
    bus.key_ready_index = 4'(kri_i);
    for (int r = 0; r < 11; r++)
      bus.w_all[1407-128*r -: 128] = (kri_i >= r + 1) ? rk(cur_w, r)
                                     : {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.in_valid = (pt_q.size() != 0) && (iv_mode == 0 || $urandom_range(1, 0) == 1);
    bus.in_data  = (pt_q.size() != 0) ? pt_q[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    case (or_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = (m_phase == 2) && (done_cnt == 20);
      default: bus.out_ready = ($urandom_range(2, 0) == 0);
    endcase
    #3;
    // compare against the reference for this cycle
    exp_en = (m_phase == 1) && (m_k >= 1) && (kri_i >= m_k + 1);
    check_eq("in_ready", 128'(bus.in_ready), 128'(m_phase == 0));
    check_eq("out_valid", 128'(bus.out_valid), 128'(m_phase == 2));
    check_eq("rd_en", 128'(bus.rd_en), 128'(exp_en));
    check_eq("rd_state", bus.rd_state, m_state);
    check_eq("out_data", bus.out_data, m_state);
    check_eq("stall_cnt", 128'(bus.stall_cnt), 128'(m_stall));
    if (m_phase == 1) check_eq("rd_last", 128'(bus.rd_last), 128'(m_k == 10));
    if (exp_en) check_eq("rd_key", bus.rd_key, rk(m_w, m_k));
    if (m_phase == 1 && m_k == 1 && m_pt == FIPS_PT && m_w == fips_w)
      check_eq("fips_round1_state", bus.rd_state, FIPS_R1);
    if (lat_armed && bus.out_valid) begin
      check_eq("latency", 128'(cyc - dut_acc_cyc), 128'(12 + m_stall));
      lat_armed = 1'b0;
    end
    if (bus.in_valid && bus.in_ready) begin
      dut_acc_cyc = cyc;
      lat_armed   = 1'b1;
    end
    if (m_phase == 2 && bus.out_ready) begin
      check_eq("ciphertext", bus.out_data, m_ct);
      if (m_pt == FIPS_PT && m_w == fips_w) check_eq("fips_ct", bus.out_data, FIPS_CT);
    end
    // advance the reference
    if (m_phase == 2) done_cnt++;
    else done_cnt = 0;
    if (!rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
          m_pt = bus.in_data; m_state = bus.in_data; m_w = cur_w;
          m_ct = aes_encrypt(bus.in_data, cur_w);
          m_k = 0; m_stall = 0; m_phase = 1;
          void'(pt_q.pop_front());
          if (kri_mode == 2) kri_walk = int'($urandom_range(3, 0));
        end
        1: if (kri_i >= m_k + 1) begin
          m_state = (m_k == 0) ? (m_state ^ rk(m_w, 0)) : aes_round(m_state, rk(m_w, m_k), m_k == 10);
          if (m_k == 10) m_phase = 2;
          else m_k++;
        end else begin
          m_stall = (m_stall == 65535) ? m_stall : m_stall + 1;
        end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
    ramp_cnt++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int budget);
    int left;
    left = budget;
    while ((pt_q.size() != 0 || m_phase != 0) && left > 0) begin
      run_cycle();
      left--;
    end
    if (left == 0) check_eq("idle_timeout", 128'(m_phase), 128'd0);
  endtask

  initial begin
    fips_w = expand(FIPS_KEY);
    cur_w = fips_w;
    kri_mode = 0; or_mode = 0; iv_mode = 0;
    ramp_cnt = 0; done_cnt = 0; kri_walk = 0; cyc = 0; dut_acc_cyc = 0;
    rst_mid_pending = 1'b0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 128'd0; bus.out_ready = 1'b0;
    bus.key_ready_index = 4'd0; bus.w_all = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check_eq("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check_eq("rst_rd_en", 128'(bus.rd_en), 128'd0);
    check_eq("rst_rd_last", 128'(bus.rd_last), 128'd0);
    check_eq("rst_out_data", bus.out_data, 128'd0);
    check_eq("rst_stall_cnt", 128'(bus.stall_cnt), 128'd0);

    // FIPS-197 C.1 with every key ready
    pt_q.push_back(FIPS_PT);
    run_until_idle(200);

    // keys arriving one every 8 cycles
    kri_mode = 1; ramp_cnt = 0;
    pt_q.push_back(FIPS_PT);
    run_until_idle(400);

    // 20 cycles of output backpressure, then a single ready pulse
    kri_mode = 0; or_mode = 1;
    pt_q.push_back(FIPS_PT);
    run_until_idle(200);

    // back-to-back blocks with in_valid held high
    or_mode = 0;
    pt_q.push_back(FIPS_PT);
    pt_q.push_back(128'd0);
    run_until_idle(300);

    // reset during round 5, then a fresh vector
    rst_mid_pending = 1'b1;
    pt_q.push_back(FIPS_PT);
    run_until_idle(200);
    check_eq("rst_mid_taken", 128'(rst_mid_pending), 128'd0);
    pt_q.push_back(FIPS_PT);
    run_until_idle(200);

    // randomized keys, plaintexts, key readiness and backpressure
    kri_mode = 2; or_mode = 2; iv_mode = 1;
    for (int b = 0; b < 25; b++) begin
      cur_w = expand({$urandom(), $urandom(), $urandom(), $urandom()});
      pt_q.push_back((b % 8 == 0) ? 128'd0 : {$urandom(), $urandom(), $urandom(), $urandom()});
      run_until_idle(2000);
    end

    $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for AES-128 encryption. It accepts one plaintext block over a valid/ready handshake and applies the round-0 AddRoundKey internally. It then drives an external single-round datapath for rounds 1..10, taking each round key from the packed key-schedule bus and stalling until the key schedule reports that the key is ready. It sits between the key schedule (`w_all`, `key_ready_index`) and the round-function datapath, and returns ciphertext over a valid/ready handshake.

## Interface
- No parameters; AES-128 only, 10 rounds fixed.
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `w_all`  in  1408  packed round keys; round key r = `w_all[1407-128*r -: 128]`, r = 0..10.
- `key_ready_index`  in  4  number of round keys ready, counting round 0; round key r is usable when `key_ready_index >= r+1`.
- `in_valid`  in  1  plaintext valid.
- `in_data`  in  128  plaintext, MSB = byte 0.
- `in_ready`  out  1  block can accept plaintext.
- `out_valid`  out  1  ciphertext valid.
- `out_data`  out  128  ciphertext.
- `out_ready`  in  1  downstream accepts ciphertext.
- `rd_state`  out  128  state presented to the round datapath.
- `rd_key`  out  128  round key for the current round.
- `rd_last`  out  1  current round is 10; datapath skips MixColumns.
- `rd_en`  out  1  the round is executing this cycle; `rd_result` is captured at the next edge.
- `rd_result`  in  128  combinational round output (SubBytes, ShiftRows, MixColumns unless `rd_last`, AddRoundKey).
- `stall_cnt`  out  16  saturating count of cycles stalled waiting on keys for the current block.

## Operation
- Registers: `state_reg[127:0]`, `round[3:0]`, `fsm[2:0]`, `stall_cnt`.
- `rd_state = state_reg`.
- `rd_key = w_all` slice for `round`.
- `rd_last = (round == 10)`.
- `out_data = state_reg`.
- S_IDLE:
  - `in_ready = 1`.
  - On `in_valid`: `state_reg <= in_data`, `round <= 0`, `stall_cnt <= 0`, go to S_ADDKEY.
- S_ADDKEY:
  - If `key_ready_index >= 1`: `state_reg <= state_reg ^ key0`, `round <= 1`, go to S_ROUND.
  - Otherwise hold and increment `stall_cnt`.
- S_ROUND:
  - `rd_en = (key_ready_index >= round+1)`.
  - When `rd_en`: `state_reg <= rd_result`.
  - If `round == 10`, go to S_DONE; otherwise `round <= round+1`.
  - When not `rd_en`: hold all state and increment `stall_cnt`.
- S_DONE:
  - `out_valid = 1`.
  - On `out_ready`, go to S_IDLE.
  - `state_reg` holds stable while waiting.
- `in_ready` and `out_valid` are combinational decodes of `fsm`. Both are 0 outside their respective states.
- `stall_cnt` saturates at 16'hFFFF; it is held in S_DONE and S_IDLE until the next accept.
- Unused `fsm` encodings go to S_IDLE.

## Timing
- Reset (`rst = 0` at an edge), outputs after that edge:
  - `fsm = S_IDLE`, `state_reg = 0`, `round = 0`, `stall_cnt = 0`.
  - `in_ready = 1`, `out_valid = 0`, `rd_en = 0`, `rd_last = 0`, `out_data = 0`.
- Reset asserted mid-operation discards the block in flight; no output is produced for it.
- No-stall latency: accept at edge E; `out_valid` is high in the cycle after edge E+11 (1 ADDKEY cycle + 10 round cycles). Throughput is one block per 12 cycles plus the output handshake.
- Simultaneous events:
  - Ciphertext handshake in S_DONE: the next plaintext can be accepted in the cycle after `out_ready`. No overlap of blocks.
  - If `key_ready_index` increases in the same cycle a round is checked, the comparison uses the current-cycle value.
- If `key_ready_index` drops, e.g. the key schedule is restarted, the controller simply stalls. It performs no rollback.
- `rd_en` is never high outside S_ROUND.
- `round` never exceeds 10.

## Test plan
- FIPS-197 C.1:
  - Stimulus: all 11 keys ready from key 000102030405060708090a0b0c0d0e0f; plaintext 00112233445566778899aabbccddeeff; reference round model attached.
  - Required: `rd_state` = 00102030405060708090a0b0c0d0e0f0 in the first S_ROUND cycle; `out_data` = 69c4e0d86a7b0430d8cdb78070b4c55a; `out_valid` rises 12 cycles after accept; `stall_cnt = 0`.
- Key stalls:
  - Stimulus: `key_ready_index` ramps by 1 every 8 cycles starting at 0; same vector.
  - Required: ciphertext identical; `rd_en` rises only once round key r is ready; `stall_cnt` equals the total stall cycles.
- Output backpressure:
  - Stimulus: hold `out_ready = 0` for 20 cycles, then pulse it.
  - Required: `out_valid` and `out_data` are stable throughout; `in_ready = 0` throughout; S_IDLE is reached the cycle after the pulse.
- Back-to-back blocks:
  - Stimulus: two plaintexts with `in_valid` held high; the second is 00000000000000000000000000000000 under the same key.
  - Required: the second is accepted exactly 1 cycle after the first output handshake; both ciphertexts are correct.
- Reset mid-operation:
  - Stimulus: assert `rst` during round 5.
  - Required: all reset values appear at the next edge; no `out_valid`; a fresh FIPS-197 vector then passes.
- Last round:
  - Required: `rd_last` is high only in the round-10 cycle; `rd_key` equals `w_all[127:0]` in that cycle.
